// File: rtl/player_motion_if.sv
// Key/control inputs and position/fire outputs of one player's motion block.
interface player_motion_if #(
    parameter int POS_W = 10
);
    logic [4:0]       keys;
    logic             enable;
    logic             respawn;
    logic [POS_W-1:0] pos_x;
    logic [POS_W-1:0] pos_y;
    logic [1:0]       facing;
    logic             moving;
    logic             fire;
    logic             cd_busy;

    modport master (
        output keys, enable, respawn,
        input  pos_x, pos_y, facing,
        input  moving, fire, cd_busy
    );

    modport slave (
        input  keys, enable, respawn,
        output pos_x, pos_y, facing,
        output moving, fire, cd_busy
    );
endinterface

// File: rtl/player_motion_ctrl.sv
// Held keys -> rate-limited clamped position, facing,
// and a one-cycle fire pulse gated by a tick-based cooldown.
module player_motion_ctrl #(
    parameter int POS_W    = 10,
    parameter int X_MAX    = 624,
    parameter int Y_MAX    = 464,
    parameter int X_INIT   = 16,
    parameter int Y_INIT   = 16,
    parameter int STEP     = 2,
    parameter int STEP_DIV = 250000,
    parameter int FIRE_CD  = 20
) (
    input  logic           clk,
    input  logic           reset,
    player_motion_if.slave pm
);
    localparam int CNT_W = $clog2(STEP_DIV);
    localparam int CD_W  = $clog2(FIRE_CD + 1);

    localparam logic [POS_W:0] STEP_E = (POS_W+1)'(STEP);
    localparam logic [POS_W:0] XMAX_E = (POS_W+1)'(X_MAX);
    localparam logic [POS_W:0] YMAX_E = (POS_W+1)'(Y_MAX);

    logic [4:0]       ks_meta;
    logic [4:0]       ks;
    logic             ks4_prev;
    logic [CNT_W-1:0] div_cnt;
    logic             tick;
    logic [CD_W-1:0]  cd;
    logic [CD_W-1:0]  cd_nx;

    logic [POS_W-1:0] pos_x, pos_y;
    logic [POS_W-1:0] x_nx, y_nx;
    logic [POS_W:0]   x_inc, y_inc;
    logic [1:0]       facing, face_nx;
    logic             moving, fire, cd_busy;

    logic v_up, v_dn, h_l, h_r;
    logic step_en, shoot_rise, fire_go;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ks_meta  <= '0;
            ks       <= '0;
            ks4_prev <= 1'b0;
        end else begin
            ks_meta  <= pm.keys;
            ks       <= ks_meta;
            ks4_prev <= ks[4];
        end
    end

    assign tick = (div_cnt == CNT_W'(STEP_DIV - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            div_cnt <= '0;
        else if (tick)
            div_cnt <= '0;
        else
            div_cnt <= div_cnt + 1'b1;
    end

    assign v_up = ks[0] & ~ks[3];
    assign v_dn = ks[3] & ~ks[0];
    assign h_l  = ks[1] & ~ks[2];
    assign h_r  = ks[2] & ~ks[1];

    assign step_en    = tick & pm.enable;
    assign shoot_rise = ks[4] & ~ks4_prev;
    assign fire_go    = shoot_rise & pm.enable
                      & (cd == '0);

    assign x_inc = {1'b0, pos_x} + STEP_E;
    assign y_inc = {1'b0, pos_y} + STEP_E;

    always_comb begin
        x_nx = pos_x;
        y_nx = pos_y;
        if (h_l)
            x_nx = ({1'b0, pos_x} < STEP_E) ? '0
                 : pos_x - POS_W'(STEP);
        else if (h_r)
            x_nx = (x_inc > XMAX_E) ? POS_W'(X_MAX)
                 : x_inc[POS_W-1:0];
        if (v_up)
            y_nx = ({1'b0, pos_y} < STEP_E) ? '0
                 : pos_y - POS_W'(STEP);
        else if (v_dn)
            y_nx = (y_inc > YMAX_E) ? POS_W'(Y_MAX)
                 : y_inc[POS_W-1:0];
    end

    // Horizontal intent wins over vertical on diagonals.
    always_comb begin
        face_nx = facing;
        priority case (1'b1)
            h_l:     face_nx = 2'd1;
            h_r:     face_nx = 2'd2;
            v_up:    face_nx = 2'd0;
            v_dn:    face_nx = 2'd3;
            default: face_nx = facing;
        endcase
    end

    always_comb begin
        cd_nx = cd;
        if (fire_go)
            cd_nx = CD_W'(FIRE_CD);
        else if (step_en && cd != '0)
            cd_nx = cd - 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pos_x   <= POS_W'(X_INIT);
            pos_y   <= POS_W'(Y_INIT);
            facing  <= 2'd0;
            moving  <= 1'b0;
            fire    <= 1'b0;
            cd      <= '0;
            cd_busy <= 1'b0;
        end else if (pm.respawn) begin
            pos_x   <= POS_W'(X_INIT);
            pos_y   <= POS_W'(Y_INIT);
            facing  <= 2'd0;
            moving  <= 1'b0;
            fire    <= 1'b0;
            cd      <= '0;
            cd_busy <= 1'b0;
        end else begin
            fire    <= fire_go;
            cd      <= cd_nx;
            cd_busy <= (cd_nx != '0);
            if (step_en) begin
                pos_x  <= x_nx;
                pos_y  <= y_nx;
                facing <= face_nx;
                moving <= (x_nx != pos_x)
                        | (y_nx != pos_y);
            end
        end
    end

    assign pm.pos_x   = pos_x;
    assign pm.pos_y   = pos_y;
    assign pm.facing  = facing;
    assign pm.moving  = moving;
    assign pm.fire    = fire;
    assign pm.cd_busy = cd_busy;
endmodule

// File: tb/tb_player_motion_ctrl.sv
// Directed bench for player_motion_ctrl with STEP_DIV=4;
// a second instance starts near the right edge for x clamping.
module tb_player_motion_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;
    int   fire_cnt = 0;

    player_motion_if pm ();
    player_motion_if pm2 ();

    player_motion_ctrl #(.STEP_DIV(4)) u_dut (
        .clk   (clk),
        .reset (reset),
        .pm    (pm)
    );

    player_motion_ctrl #(
        .STEP_DIV(4),
        .X_INIT  (622)
    ) u_edge (
        .clk   (clk),
        .reset (reset),
        .pm    (pm2)
    );

    always #5 clk = ~clk;

    always @(negedge clk)
        if (pm.fire === 1'b1) fire_cnt++;

    task automatic chk(input string tag,
                       input int got,
                       input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d",
                      tag, got, exp);
    endtask

    task automatic clk_n(input int n);
        repeat (n) begin
            @(posedge clk);
            cyc++;
        end
        #1;
    endtask

    // Move ticks land on edges where cyc is a multiple of 4.
    task automatic next_tick();
        clk_n(4 - (cyc % 4));
    endtask

    initial begin
        pm.keys = 5'b11111;
        pm.enable = 1'b1;
        pm.respawn = 1'b0;
        pm2.keys = 5'b00100;
        pm2.enable = 1'b1;
        pm2.respawn = 1'b0;

        // T1 reset with all keys held
        clk_n(3);
        chk("rst_x", pm.pos_x, 16);
        chk("rst_y", pm.pos_y, 16);
        chk("rst_face", pm.facing, 0);
        chk("rst_fire", pm.fire, 0);
        chk("rst_cd", pm.cd_busy, 0);
        chk("rst_mov", pm.moving, 0);
        pm.keys = 5'b00000;
        clk_n(2);
        reset = 1'b0;
        cyc = 0;

        // T2 right held, sync + tick latency
        pm.keys = 5'b00100;
        clk_n(3);
        chk("lat_x", pm.pos_x, 16);
        clk_n(1);
        chk("t1_x", pm.pos_x, 18);
        chk("t1_mov", pm.moving, 1);
        repeat (9) next_tick();
        chk("t10_x", pm.pos_x, 36);
        chk("t10_y", pm.pos_y, 16);
        chk("t10_face", pm.facing, 2);
        chk("t10_mov", pm.moving, 1);

        // T3 respawn then up to the top clamp
        pm.respawn = 1'b1;
        pm.keys = 5'b00001;
        clk_n(1);
        pm.respawn = 1'b0;
        chk("rsp_x", pm.pos_x, 16);
        chk("rsp_face", pm.facing, 0);
        chk("rsp_mov", pm.moving, 0);
        next_tick();
        chk("up1_y", pm.pos_y, 14);
        chk("up1_face", pm.facing, 0);
        repeat (7) next_tick();
        chk("up8_y", pm.pos_y, 0);
        chk("up8_mov", pm.moving, 1);
        repeat (2) next_tick();
        chk("clamp_y", pm.pos_y, 0);
        chk("clamp_mov", pm.moving, 0);
        chk("clamp_x", pm.pos_x, 16);
        chk("xmax_x", pm2.pos_x, 624);
        chk("xmax_mov", pm2.moving, 0);
        chk("xmax_face", pm2.facing, 2);

        // T4 opposite keys, then diagonal
        pm.respawn = 1'b1;
        pm.keys = 5'b01001;
        clk_n(1);
        pm.respawn = 1'b0;
        next_tick();
        chk("opp_y", pm.pos_y, 16);
        chk("opp_mov", pm.moving, 0);
        pm.keys = 5'b00011;
        next_tick();
        chk("dg1_x", pm.pos_x, 14);
        chk("dg1_y", pm.pos_y, 14);
        chk("dg1_face", pm.facing, 1);
        next_tick();
        chk("dg2_x", pm.pos_x, 12);
        chk("dg2_y", pm.pos_y, 12);
        pm.keys = 5'b00000;
        next_tick();
        chk("idle_mov", pm.moving, 0);
        chk("idle_face", pm.facing, 1);

        // T5 fire and cooldown
        pm.keys = 5'b10000;
        clk_n(3);
        chk("fire_hi", pm.fire, 1);
        chk("fire_cd", pm.cd_busy, 1);
        clk_n(1);
        chk("fire_lo", pm.fire, 0);
        repeat (12) next_tick();
        chk("hold_cnt", fire_cnt, 1);
        chk("hold_cd", pm.cd_busy, 1);
        pm.keys = 5'b00000;
        next_tick();
        pm.keys = 5'b10000;
        next_tick();
        chk("drop_cnt", fire_cnt, 1);
        pm.keys = 5'b00000;
        repeat (4) next_tick();
        chk("cd_last", pm.cd_busy, 1);
        next_tick();
        chk("cd_done", pm.cd_busy, 0);
        pm.keys = 5'b10000;
        clk_n(3);
        chk("refire", pm.fire, 1);
        next_tick();
        repeat (49) next_tick();
        chk("long_cnt", fire_cnt, 2);
        chk("long_cd", pm.cd_busy, 0);
        pm.keys = 5'b00000;

        // T6 disabled movement and firing
        pm.enable = 1'b0;
        pm.keys = 5'b00100;
        repeat (5) next_tick();
        chk("dis_x", pm.pos_x, 12);
        chk("dis_y", pm.pos_y, 12);
        chk("dis_face", pm.facing, 1);
        pm.keys = 5'b10100;
        clk_n(4);
        chk("dis_fire", fire_cnt, 2);
        pm.enable = 1'b1;
        next_tick();
        chk("en_x", pm.pos_x, 14);
        chk("en_face", pm.facing, 2);
        chk("en_fire", fire_cnt, 2);

        // Respawn on the same edge as tick and shoot rise
        pm.keys = 5'b00100;
        clk_n(1);
        pm.keys = 5'b10100;
        clk_n(2);
        pm.respawn = 1'b1;
        clk_n(1);
        pm.respawn = 1'b0;
        chk("rc_x", pm.pos_x, 16);
        chk("rc_y", pm.pos_y, 16);
        chk("rc_fire", pm.fire, 0);
        chk("rc_cd", pm.cd_busy, 0);
        chk("rc_face", pm.facing, 0);
        clk_n(2);
        chk("rc_cnt", fire_cnt, 2);

        // Async reset mid-move
        next_tick();
        chk("pre_x", pm.pos_x, 18);
        #3 reset = 1'b1;
        #1;
        chk("ar_x", pm.pos_x, 16);
        chk("ar_face", pm.facing, 0);
        chk("ar_mov", pm.moving, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
